// File: rtl/ooo_read_responder.sv
// ooo_read_responder
//   Memory-side AR/R target. It accepts read requests by ID into DEPTH slots. Each slot
//   returns a single R beat after a per-request latency. rdata is the acceptance sequence
//   number. Responses that share an ID come back in the order they were accepted.
//   Responses with different IDs may come back out of order.
//
//   Build option RESP_JITTER_EN: when defined, an 8-bit LFSR adds 0..2^JITTER_BITS-1
//   cycles of latency to each request. When it is undefined, every request takes exactly
//   MIN_LAT cycles and the LFSR is not built.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   s_arid_i      AR request ID
//   s_arvalid_i   AR valid
//   s_arready_o   AR ready, high while any slot is free (derived from state only)
//   s_rdata_o     R data (registered)
//   s_rid_o       R ID (registered)
//   s_rvalid_o    R valid (registered)
//   s_rready_i    R ready
module ooo_read_responder #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MIN_LAT     = 2,
    parameter int unsigned JITTER_BITS = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned MAX_LAT = MIN_LAT + (1 << JITTER_BITS) - 1;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam int unsigned OLD_W   = $clog2(DEPTH);
    localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    // Elaboration-time parameter sanity check
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_LAT < 1 ||
        JITTER_BITS < 1 || JITTER_BITS > 8 || SEED_EFF == 8'h00) begin : g_param_check
        $error("ooo_read_responder: illegal parameter combination");
    end

    // Slot state
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ID_WIDTH-1:0]   id_q    [DEPTH];
    logic [ID_WIDTH-1:0]   id_d    [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic [CNT_W-1:0]      cnt_q   [DEPTH];
    logic [CNT_W-1:0]      cnt_d   [DEPTH];
    logic [OLD_W-1:0]      older_q [DEPTH];
    logic [OLD_W-1:0]      older_d [DEPTH];

    // Output register and bookkeeping
    logic                  rvalid_q, rvalid_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] seq_q, seq_d;
    logic [IDX_W-1:0]      rr_q, rr_d;

    logic [DEPTH-1:0]       elig_c;
    logic [IDX_W-1:0]       alloc_idx_c;
    logic [IDX_W-1:0]       pick_idx_c;
    logic                   pick_found_c;
    logic                   out_free_c;
    logic                   issue_c;
    logic                   accept_c;
    logic [OLD_W-1:0]       same_id_cnt_c;
    logic [JITTER_BITS-1:0] jitter_c;

`ifdef RESP_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; the low bits give the per-request jitter
    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        jitter_c = lfsr_q[JITTER_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        jitter_c = '0;
    end
`endif

    assign s_arready_o = ~&valid_q;
    assign s_rvalid_o  = rvalid_q;
    assign s_rid_o     = rid_q;
    assign s_rdata_o   = rdata_q;

    // Find the lowest free slot, the round-robin eligible slot, and the issue/accept decisions
    always_comb begin
        alloc_idx_c  = '0;
        pick_idx_c   = '0;
        pick_found_c = 1'b0;
        elig_c       = '0;

        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx_c = IDX_W'(i);
            end
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            elig_c[i] = valid_q[i] && (cnt_q[i] == '0) && (older_q[i] == '0);
        end

        // Index arithmetic is IDX_W wide, so the scan wraps naturally (DEPTH is a power of 2)
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!pick_found_c && elig_c[rr_q + IDX_W'(k)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = rr_q + IDX_W'(k);
            end
        end

        out_free_c = !rvalid_q || s_rready_i;
        issue_c    = out_free_c && pick_found_c;
        accept_c   = s_arvalid_i && s_arready_o;

        // A slot that issues on this edge is not counted as older than the new request
        same_id_cnt_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (id_q[i] == s_arid_i) &&
                !(issue_c && (IDX_W'(i) == pick_idx_c))) begin
                same_id_cnt_c = same_id_cnt_c + OLD_W'(1);
            end
        end
    end

    // Next-state computation for the slots and the output register
    always_comb begin
        valid_d  = valid_q;
        id_d     = id_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        older_d  = older_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        seq_d    = seq_q;
        rr_d     = rr_q;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        if (issue_c) begin
            valid_d[pick_idx_c] = 1'b0;
            rvalid_d            = 1'b1;
            rid_d               = id_q[pick_idx_c];
            rdata_d             = data_q[pick_idx_c];
            rr_d                = pick_idx_c + IDX_W'(1);
            // Younger requests with the same ID move one step closer to the head
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && (IDX_W'(i) != pick_idx_c) &&
                    (id_q[i] == id_q[pick_idx_c]) && (older_q[i] != '0)) begin
                    older_d[i] = older_q[i] - OLD_W'(1);
                end
            end
        end else if (rvalid_q && s_rready_i) begin
            rvalid_d = 1'b0;
        end

        if (accept_c) begin
            valid_d[alloc_idx_c] = 1'b1;
            id_d[alloc_idx_c]    = s_arid_i;
            data_d[alloc_idx_c]  = seq_q;
            cnt_d[alloc_idx_c]   = CNT_W'(MIN_LAT) + CNT_W'(jitter_c);
            older_d[alloc_idx_c] = same_id_cnt_c;
            seq_d                = seq_q + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            seq_q    <= '0;
            rr_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                id_q[i]    <= '0;
                data_q[i]  <= '0;
                cnt_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            seq_q    <= seq_d;
            rr_q     <= rr_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                id_q[i]    <= id_d[i];
                data_q[i]  <= data_d[i];
                cnt_q[i]   <= cnt_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ooo_read_responder.sv
// Bench for ooo_read_responder. Directed vectors, hand-written corner sequences and random
// traffic. Every cycle is checked against a request-list reference model that works from
// absolute ready times and acceptance order.
module tb_ooo_read_responder;

    localparam int unsigned DW      = 8;
    localparam int unsigned IW      = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MIN_LAT = 2;
    localparam int unsigned JB      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] arid;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic          rvalid;
    logic          rready;

    always #5 clk = ~clk;

    ooo_read_responder #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .DEPTH      (DEPTH),
        .MIN_LAT    (MIN_LAT),
        .JITTER_BITS(JB),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_arid_i   (arid),
        .s_arvalid_i(arvalid),
        .s_arready_o(arready),
        .s_rdata_o  (rdata),
        .s_rid_o    (rid),
        .s_rvalid_o (rvalid),
        .s_rready_i (rready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_v     [DEPTH];
    int m_id    [DEPTH];
    int m_data  [DEPTH];
    int m_rdy   [DEPTH];   // first edge index at which the request may issue
    int m_ord   [DEPTH];   // acceptance order, unwrapped
    int m_rr;
    bit m_rvalid;
    int m_rid;
    int m_rdata;
    int m_seq;
    int cyc = 0;
`ifdef RESP_JITTER_EN
    logic [7:0] m_lfsr;
`endif

    int q_rid[$];
    int q_rdata[$];

    function automatic bit m_arready();
        bit r = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) if (!m_v[i]) r = 1'b1;
        return r;
    endfunction

    function automatic bit m_blocked(input int i);
        bit r = 1'b0;
        for (int j = 0; j < int'(DEPTH); j++)
            if (m_v[j] && m_id[j] == m_id[i] && m_ord[j] < m_ord[i]) r = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int alloc;
        int pick;
        int jit;
        int s;
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) m_v[i] = 1'b0;
            m_rvalid = 1'b0;
            m_rid    = 0;
            m_rdata  = 0;
            m_seq    = 0;
            m_rr     = 0;
`ifdef RESP_JITTER_EN
            m_lfsr = 8'hA5;
`endif
        end else begin
            alloc = -1;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) if (!m_v[i]) alloc = i;
`ifdef RESP_JITTER_EN
            jit = int'(m_lfsr) % (1 << JB);
`else
            jit = 0;
`endif
            pick = -1;
            if (!m_rvalid || rready) begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    s = (m_rr + k) % int'(DEPTH);
                    if (pick < 0 && m_v[s] && cyc >= m_rdy[s] && !m_blocked(s)) pick = s;
                end
            end
            if (pick >= 0) begin
                m_rvalid = 1'b1;
                m_rid    = m_id[pick];
                m_rdata  = m_data[pick];
                m_v[pick] = 1'b0;
                m_rr     = (pick + 1) % int'(DEPTH);
            end else if (m_rvalid && rready) begin
                m_rvalid = 1'b0;
            end
            if (arvalid && alloc >= 0) begin
                m_v[alloc]    = 1'b1;
                m_id[alloc]   = int'(arid);
                m_data[alloc] = m_seq % (1 << DW);
                m_ord[alloc]  = m_seq;
                m_rdy[alloc]  = cyc + int'(MIN_LAT) + jit + 1;
                m_seq++;
            end
`ifdef RESP_JITTER_EN
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        end
        cyc++;
    endtask

    // One clock: log R handshakes, step the model, then compare just after the edge
    task automatic do_cycle();
        if (rvalid === 1'b1 && rready) begin
            q_rid.push_back(int'(rid));
            q_rdata.push_back(int'(rdata));
        end
        model_edge();
        @(posedge clk);
        #1;
        chk("model_arready", int'(arready), int'(m_arready()));
        chk("model_rvalid", int'(rvalid), int'(m_rvalid));
        chk("model_rid", int'(rid), m_rid);
        chk("model_rdata", int'(rdata), m_rdata);
    endtask

    task automatic set_in(input bit r, input bit av, input int id, input bit rr);
        rst     = r;
        arvalid = av;
        arid    = IW'(id);
        rready  = rr;
    endtask

    typedef struct {
        bit rst;
        bit arvalid;
        int arid;
        bit rready;
        bit e_arready;
        bit e_rvalid;
        int e_rid;
        int e_rdata;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit av, input int id, input bit rr,
                                input bit ea, input bit ev, input int eid, input int ed);
        vec_t v;
        v.rst = r; v.arvalid = av; v.arid = id; v.rready = rr;
        v.e_arready = ea; v.e_rvalid = ev; v.e_rid = eid; v.e_rdata = ed;
        return v;
    endfunction

    initial begin
        vec_t tbl[11];
        int   exp_d[5];
        int   mask;

        set_in(1'b1, 1'b0, 0, 1'b0);

`ifndef RESP_JITTER_EN
        // Reset, then a single AR id 4 held unanswered (fixed latency build)
        tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 4, 0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 1, 4, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 1, 4, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 4, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 1, 4, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 1, 4, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 0, 4, 0);
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].rst, tbl[i].arvalid, tbl[i].arid, tbl[i].rready);
            do_cycle();
            chk($sformatf("vec%0d_arready", i), int'(arready), int'(tbl[i].e_arready));
            chk($sformatf("vec%0d_rvalid", i), int'(rvalid), int'(tbl[i].e_rvalid));
            chk($sformatf("vec%0d_rid", i), int'(rid), tbl[i].e_rid);
            chk($sformatf("vec%0d_rdata", i), int'(rdata), tbl[i].e_rdata);
        end

        // Fill all slots with the output register stalled, then release one beat
        set_in(1, 0, 0, 0); do_cycle();
        set_in(0, 1, 1, 0); do_cycle();
        set_in(0, 1, 2, 0); do_cycle();
        set_in(0, 1, 3, 0); do_cycle();
        set_in(0, 1, 5, 0); do_cycle();
        chk("t3_first_rvalid", int'(rvalid), 1);
        chk("t3_first_rid", int'(rid), 1);
        chk("t3_first_rdata", int'(rdata), 0);
        set_in(0, 1, 6, 0); do_cycle();
        chk("t3_full_arready", int'(arready), 0);
        set_in(0, 1, 8, 0);
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            chk("t3_stall_arready", int'(arready), 0);
            chk("t3_stall_rid", int'(rid), 1);
            chk("t3_stall_rdata", int'(rdata), 0);
        end
        set_in(0, 1, 8, 1); do_cycle();
        chk("t3_reload_rid", int'(rid), 2);
        chk("t3_reload_rdata", int'(rdata), 1);
        chk("t3_reload_arready", int'(arready), 1);
        set_in(0, 1, 8, 0); do_cycle();
        chk("t3_late_accept_arready", int'(arready), 0);
        q_rid.delete(); q_rdata.delete();
        set_in(0, 0, 0, 1);
        for (int k = 0; k < 20 && q_rdata.size() < 5; k++) do_cycle();
        chk("t3_drain_count", q_rdata.size(), 5);
        exp_d = '{1, 2, 3, 4, 5};
        for (int k = 0; k < 5 && k < q_rdata.size(); k++)
            chk($sformatf("t3_drain_rdata%0d", k), q_rdata[k], exp_d[k]);
`endif

        // Same-ID ordering
        set_in(1, 0, 0, 1); do_cycle();
        q_rid.delete(); q_rdata.delete();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 7, 1); do_cycle();
        end
        set_in(0, 0, 0, 1);
        for (int k = 0; k < 40 && q_rdata.size() < 3; k++) do_cycle();
        chk("t4_count", q_rdata.size(), 3);
        for (int k = 0; k < 3 && k < q_rdata.size(); k++) begin
            chk($sformatf("t4_rid%0d", k), q_rid[k], 7);
            chk($sformatf("t4_rdata%0d", k), q_rdata[k], k);
        end

        // Distinct IDs 0..3, each returned exactly once with its acceptance index
        set_in(1, 0, 0, 1); do_cycle();
        q_rid.delete(); q_rdata.delete();
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1, k, 1); do_cycle();
        end
        set_in(0, 0, 0, 1);
        for (int k = 0; k < 40 && q_rdata.size() < 4; k++) do_cycle();
        chk("t5_count", q_rdata.size(), 4);
        mask = 0;
        for (int k = 0; k < q_rdata.size(); k++) begin
            chk($sformatf("t5_rdata_vs_id%0d", k), q_rdata[k], q_rid[k]);
            mask = mask | (1 << (q_rid[k] % 16));
        end
        chk("t5_id_mask", mask, 15);

        // Reset with requests pending
        set_in(1, 0, 0, 0); do_cycle();
        set_in(0, 1, 1, 0); do_cycle();
        set_in(0, 1, 2, 0); do_cycle();
        set_in(1, 0, 0, 0); do_cycle();
        chk("t6_rst_rvalid", int'(rvalid), 0);
        chk("t6_rst_arready", int'(arready), 1);
        chk("t6_rst_rid", int'(rid), 0);
        chk("t6_rst_rdata", int'(rdata), 0);
        set_in(0, 1, 9, 0); do_cycle();
        set_in(0, 0, 0, 0);
        for (int k = 0; k < 12 && rvalid !== 1'b1; k++) do_cycle();
        chk("t6_after_rvalid", int'(rvalid), 1);
        chk("t6_after_rid", int'(rid), 9);
        chk("t6_after_rdata", int'(rdata), 0);

        // Random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            set_in($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
